// File: rtl/segre_pkg.sv
// Shared types for the decode-stage hazard controller: bypass selects and the
// shadow scoreboard slot describing an in-flight destination register.
package segre_pkg;

  localparam int REG_SIZE  = 5;
  localparam int WORD_SIZE = 32;

  typedef enum logic [1:0] {
    ID_RF            = 2'd0,
    EXECUTE_BYPASS   = 2'd1,
    MEMORY_BYPASS    = 2'd2,
    WRITEBACK_BYPASS = 2'd3
  } bypass_id_sel_e;

  typedef struct packed {
    logic                valid;
    logic                we;
    logic [REG_SIZE-1:0] waddr;
    logic                prod_ex;
    logic                prod_mem;
  } hazard_slot_t;

  // x0 is hardwired to zero, so it never needs forwarding
  function automatic logic slot_match(input hazard_slot_t slot, input logic rd_en,
                                      input logic [REG_SIZE-1:0] src);
    return rd_en && slot.valid && slot.we && (slot.waddr == src) &&
           (src != {REG_SIZE{1'b0}});
  endfunction

endpackage

// File: rtl/segre_bypass_sel.sv
// Bypass select for one ID source operand: youngest producer wins, and an EX
// producer whose value only exists after MEM is reported as a load-use hazard.
module segre_bypass_sel
  import segre_pkg::*;
(
  input  logic                rd_en,
  input  logic [REG_SIZE-1:0] src,
  input  hazard_slot_t        ex_slot,
  input  hazard_slot_t        mem_slot,
  input  hazard_slot_t        wb_slot,
  output bypass_id_sel_e      sel,
  output logic                load_use
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign ex_hit  = slot_match(ex_slot, rd_en, src);
  assign mem_hit = slot_match(mem_slot, rd_en, src);
  assign wb_hit  = slot_match(wb_slot, rd_en, src);

  // Priority chain from youngest (EX) to oldest (WB) producer
  always_comb begin
    sel      = ID_RF;
    load_use = 1'b0;
    if (ex_hit && ex_slot.prod_ex) begin
      sel = EXECUTE_BYPASS;
    end else if (ex_hit && ex_slot.prod_mem) begin
      load_use = 1'b1;
    end else if (mem_hit) begin
      sel = MEMORY_BYPASS;
    end else if (wb_hit) begin
      sel = WRITEBACK_BYPASS;
    end else begin
      sel = ID_RF;
    end
  end

endmodule

// File: rtl/segre_hazard_controller.sv
// Decode-stage pipeline controller: shadow scoreboard of EX/MEM/WB writers,
// bypass selects, load-use stall, branch flush sequencing and memory freeze.
module segre_hazard_controller
  import segre_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_CNT_W  = 32
) (
  input  logic                   clk_i,
  input  logic                   rsn_i,
  input  logic                   valid_id_i,
  input  logic                   rd_raddr_a_i,
  input  logic                   rd_raddr_b_i,
  input  logic [REG_SIZE-1:0]    src_a_identifier_i,
  input  logic [REG_SIZE-1:0]    src_b_identifier_i,
  input  logic                   rf_we_i,
  input  logic [REG_SIZE-1:0]    rf_waddr_i,
  input  logic                   prod_data_stage_ex_i,
  input  logic                   prod_data_stage_mem_i,
  input  logic                   branch_taken_i,
  input  logic                   mem_stall_i,
  output bypass_id_sel_e         mux_sel_a_id_o,
  output bypass_id_sel_e         mux_sel_b_id_o,
  output logic                   block_if_o,
  output logic                   block_id_o,
  output logic                   inject_nops_o,
  output logic                   bubble_ex_o,
  output logic                   freeze_o,
  output logic [STALL_CNT_W-1:0] stall_cycles_o
);

  hazard_slot_t   ex_slot;
  hazard_slot_t   mem_slot;
  hazard_slot_t   wb_slot;
  hazard_slot_t   id_slot;
  logic [2:0]     flush_cnt;
  bypass_id_sel_e sel_a;
  bypass_id_sel_e sel_b;
  logic           lu_a;
  logic           lu_b;
  logic           load_use;
  logic           flush_active;
  logic           issue;

  segre_bypass_sel u_sel_a (
    .rd_en    (rd_raddr_a_i),
    .src      (src_a_identifier_i),
    .ex_slot  (ex_slot),
    .mem_slot (mem_slot),
    .wb_slot  (wb_slot),
    .sel      (sel_a),
    .load_use (lu_a)
  );

  segre_bypass_sel u_sel_b (
    .rd_en    (rd_raddr_b_i),
    .src      (src_b_identifier_i),
    .ex_slot  (ex_slot),
    .mem_slot (mem_slot),
    .wb_slot  (wb_slot),
    .sel      (sel_b),
    .load_use (lu_b)
  );

  assign load_use     = valid_id_i && (lu_a || lu_b);
  assign flush_active = branch_taken_i || (flush_cnt != 3'd0);
  assign issue        = valid_id_i && !load_use && !flush_active;

  assign id_slot = '{valid:    1'b1,
                     we:       rf_we_i,
                     waddr:    rf_waddr_i,
                     prod_ex:  prod_data_stage_ex_i,
                     prod_mem: prod_data_stage_mem_i};

  // Control outputs; reset forces them to their idle values without a clock
  always_comb begin
    mux_sel_a_id_o = ID_RF;
    mux_sel_b_id_o = ID_RF;
    block_if_o     = 1'b0;
    block_id_o     = 1'b0;
    inject_nops_o  = 1'b0;
    bubble_ex_o    = 1'b0;
    freeze_o       = 1'b0;
    if (!rsn_i) begin
      freeze_o = 1'b0;
    end else begin
      mux_sel_a_id_o = sel_a;
      mux_sel_b_id_o = sel_b;
      if (mem_stall_i) begin
        freeze_o   = 1'b1;
        block_if_o = 1'b1;
        block_id_o = 1'b1;
      end else if (flush_active) begin
        inject_nops_o = 1'b1;
        bubble_ex_o   = 1'b1;
      end else if (load_use) begin
        block_if_o  = 1'b1;
        block_id_o  = 1'b1;
        bubble_ex_o = 1'b1;
      end else begin
        freeze_o = 1'b0;
      end
    end
  end

  // Shadow scoreboard and flush counter; both hold while MEM is stalled
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      ex_slot   <= '0;
      mem_slot  <= '0;
      wb_slot   <= '0;
      flush_cnt <= 3'd0;
    end else if (!mem_stall_i) begin
      wb_slot  <= mem_slot;
      mem_slot <= ex_slot;
      ex_slot  <= issue ? id_slot : hazard_slot_t'(0);
      if (branch_taken_i) begin
        flush_cnt <= 3'(FLUSH_CYCLES - 1);
      end else if (flush_cnt != 3'd0) begin
        flush_cnt <= flush_cnt - 3'd1;
      end else begin
        flush_cnt <= flush_cnt;
      end
    end else begin
      flush_cnt <= flush_cnt;
    end
  end

  // Performance counter of cycles the IF/ID register was held
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      stall_cycles_o <= '0;
    end else if (block_id_o) begin
      stall_cycles_o <= stall_cycles_o + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cycles_o <= stall_cycles_o;
    end
  end

endmodule
